out_mem: RTL

OUT_MEM -- requirements
Module: out_mem

---
 rtl/out_mem_pkg.sv | 9 +
 rtl/spike_fifo.sv | 41 ++++
 rtl/out_mem.sv | 79 +++++++
 3 files changed

// File: rtl/out_mem_pkg.sv
// Shared types and default sizing for the output spike memory.
package out_mem_pkg;
  localparam int NEURONS_DEF = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  typedef logic [NEURONS_DEF-1:0] spike_vec_t;
endpackage

// File: rtl/spike_fifo.sv
// Spike-vector FIFO: first-word fall-through from storage, no bypass path.
module spike_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // storage needs no reset; dout is gated by empty
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign dout  = empty ? '0 : mem[rptr];
endmodule

// File: rtl/out_mem.sv
// Output-layer spike memory: buffers spike vectors and keeps per-neuron frame totals.
module out_mem
  import out_mem_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       outmem_enable,
  input  logic                       spike_in [NEURONS],
  input  logic                       frame_last,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic                       data_out [NEURONS],
  output logic [CNT_W-1:0]           spike_cnt [NEURONS],
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       out_done
);
  state_t               state, state_nx;
  logic [NEURONS-1:0]   spk, head;
  logic                 full, empty, push, pop, accepting;

  always_comb
    for (int i = 0; i < NEURONS; i++) begin
      spk[i]      = spike_in[i];
      data_out[i] = head[i];
    end

  assign accepting = (state == IDLE) || (state == COLLECT);
  assign pop       = rd_valid & rd_ready;
  assign push      = outmem_enable & accepting & (~full | pop);
  assign rd_valid  = ~empty;
  assign out_done  = (state == DONE);

  spike_fifo #(.W(NEURONS), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (spk),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, COLLECT: if (push) state_nx = frame_last ? DRAIN : COLLECT;
      DRAIN:         if (level == '0) state_nx = DONE;
      DONE:          state_nx = IDLE;
      default:       state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (outmem_enable && !push) overflow <= 1'b1;
  end

  // first push of a frame restarts the totals instead of accumulating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEURONS; i++) spike_cnt[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < NEURONS; i++)
        if (state == IDLE)         spike_cnt[i] <= CNT_W'(spk[i]);
        else if (spike_cnt[i] != '1) spike_cnt[i] <= spike_cnt[i] + CNT_W'(spk[i]);
    end
  end
endmodule
